// File: rtl/ro_ram_reader.sv
// Drains the ring-oscillator sample RAM over port B and sends each word as four bytes, MSB first, on a valid/ready stream.
// Optional stream header is built when RO_READER_HEADER_EN is defined.
module ro_ram_reader #(
  parameter int ADDR_W     = 13,
  parameter int RD_LATENCY = 1
) (
  input  logic              read_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   sample_count,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       ram_dout,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
`ifdef RO_READER_HEADER_EN
    S_HDR  = 3'd1,
`endif
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_SEND = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         shift_q, shift_d;
  logic [1:0]          byte_q, byte_d;
  logic [1:0]          wait_q, wait_d;
  logic                zero_q, zero_d;

`ifdef RO_READER_HEADER_EN
  logic [31:0] hdr_cnt;
  assign hdr_cnt = 32'(remaining_q);
`endif

  always_ff @(posedge read_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      wait_q      <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      wait_q      <= wait_d;
      zero_q      <= zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    wait_d      = wait_q;
    zero_d      = zero_q;
    ram_en      = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    busy        = 1'b1;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          remaining_d = sample_count[ADDR_W] ? MAX_CNT : sample_count;
          addr_d      = '0;
          byte_d      = '0;
`ifdef RO_READER_HEADER_EN
          state_d = S_HDR;
`else
          if (remaining_d != '0) begin
            state_d = S_RD;
          end else begin
            state_d = S_FIN;
            zero_d  = 1'b1;
          end
`endif
        end
      end
`ifdef RO_READER_HEADER_EN
      S_HDR: begin
        tx_valid = 1'b1;
        case (byte_q)
          2'd0:    tx_data = 8'hA5;
          2'd1:    tx_data = 8'h5A;
          2'd2:    tx_data = hdr_cnt[15:8];
          default: tx_data = hdr_cnt[7:0];
        endcase
        if (tx_ready) begin
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) state_d = (remaining_q != '0) ? S_RD : S_FIN;
        end
      end
`endif
      S_RD: begin
        ram_en  = 1'b1;
        wait_d  = 2'(RD_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 2'd0) begin
          shift_d = ram_dout;
          byte_d  = '0;
          state_d = S_SEND;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift_q[31:24];
        if (tx_ready) begin
          shift_d = {shift_q[23:0], 8'h00};
          byte_d  = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            remaining_d = remaining_q - 1'b1;
            // addr stops on the last word so it never wraps within a drain
            if (remaining_q != 1) begin
              addr_d  = addr_q + 1'b1;
              state_d = S_RD;
            end else begin
              state_d = S_FIN;
            end
          end
        end
      end
      S_FIN: begin
        // a zero-length drain lingers here one cycle so busy shows and done lands two cycles after start
        if (zero_q) begin
          zero_d = 1'b0;
        end else begin
          done    = 1'b1;
          busy    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_addr = addr_q;

endmodule

// File: tb/tb_ro_ram_reader.sv
// Scoreboard bench for ro_ram_reader: stimulus pushes expected bytes/addresses, a negedge monitor pops and compares.
module tb_ro_ram_reader;
  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   sample_count = '0;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_dout = '0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              busy;
  logic              done;

  ro_ram_reader #(.ADDR_W(ADDR_W), .RD_LATENCY(1)) dut (
    .read_clk(clk), .rst(rst), .start(start), .sample_count(sample_count),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  int total = 0, passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int done_cnt = 0, xfer_cnt = 0;
  int first_en_cyc = -1, first_valid_cyc = -1, done_cyc = -1;
  bit rand_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor
  logic       prev_stall = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("unexpected tx byte", {24'h0, tx_data}, 32'hxxxxxxxx);
        else chk("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        xfer_cnt++;
      end
      if (ram_en) begin
        if (exp_addr_q.size() == 0) chk("unexpected ram_en", 32'(ram_addr), 32'hxxxxxxxx);
        else chk("ram_addr", 32'(ram_addr), 32'(exp_addr_q.pop_front()));
        if (first_en_cyc < 0) first_en_cyc = cyc;
      end
      if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && !prev_rst) begin
        chk("stall holds valid", {31'h0, tx_valid}, 32'h1);
        chk("stall holds data", {24'h0, tx_data}, {24'h0, prev_data});
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy low with done", {31'h0, busy}, 32'h0);
      end
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    prev_rst   = rst;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_mode) tx_ready = 1'($urandom_range(0, 1));
      else tx_ready = 1'b1;
    end
  end

  task automatic push_expected(input int count);
`ifdef RO_READER_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(count >> 8));
    exp_q.push_back(8'(count));
`endif
    for (int i = 0; i < count; i++) begin
      logic [31:0] w;
      w = mem[i];
      exp_addr_q.push_back(ADDR_W'(i));
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
  endtask

  task automatic drain(input int count, input bit rnd, input bit extra_start, input bit check_lat);
    int c0, d0, budget;
    bit got;
    push_expected(count);
    rand_mode = rnd;
    @(posedge clk); #2;
    first_en_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
    d0 = done_cnt;
    c0 = cyc;
    start = 1'b1;
    sample_count = (ADDR_W+1)'(count);
    @(posedge clk); #2;
    start = 1'b0;
    sample_count = '0;
    chk("busy after start", {31'h0, busy}, 32'h1);
    if (extra_start) begin
      repeat (10) @(posedge clk);
      #2 start = 1'b1; sample_count = 1;
      @(posedge clk); #2 start = 1'b0; sample_count = '0;
    end
    budget = count * 40 + 60;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      if (done_cnt != d0) got = 1;
    end
    if (!got) chk("done within budget", 32'h0, 32'h1);
    rand_mode = 0;
    repeat (3) @(posedge clk);
    chk("single done pulse", 32'(done_cnt - d0), 32'h1);
    chk("all bytes sent", 32'(exp_q.size()), 32'h0);
    chk("all reads issued", 32'(exp_addr_q.size()), 32'h0);
`ifndef RO_READER_HEADER_EN
    if (check_lat) begin
      if (count == 0) begin
        chk("zero count done cycle", 32'(done_cyc - c0), 32'd2);
        chk("zero count no ram_en", 32'(first_en_cyc), 32'hffffffff);
        chk("zero count no tx_valid", 32'(first_valid_cyc), 32'hffffffff);
      end else begin
        chk("ram_en latency", 32'(first_en_cyc - c0), 32'd1);
        chk("tx_valid latency", 32'(first_valid_cyc - c0), 32'd3);
      end
    end
`endif
  endtask

  initial begin
    int x0, d0;
    bit got;
    mem[0] = 32'h11223344;
    mem[1] = 32'hAABBCCDD;
    mem[2] = 32'h00000001;
    repeat (3) @(posedge clk);
    #2;
    chk("reset ram_en", {31'h0, ram_en}, 32'h0);
    chk("reset ram_addr", 32'(ram_addr), 32'h0);
    chk("reset tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("reset tx_data", {24'h0, tx_data}, 32'h0);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    drain(3, 0, 0, 1);
    drain(3, 1, 1, 0);
    drain(0, 0, 0, 1);

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = i;
    drain(1 << ADDR_W, 0, 0, 1);

    mem[0] = 32'h11223344;
    mem[1] = 32'hAABBCCDD;
    mem[2] = 32'h00000001;
    push_expected(3);
    x0 = xfer_cnt;
    d0 = done_cnt;
    @(posedge clk); #2 start = 1'b1; sample_count = 3;
    @(posedge clk); #2 start = 1'b0; sample_count = '0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      if (xfer_cnt - x0 >= 5) got = 1;
    end
    if (!got) chk("five bytes before reset", 32'h0, 32'h1);
    #1 rst = 1'b1;
    @(posedge clk); #2;
    chk("mid reset tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid reset busy", {31'h0, busy}, 32'h0);
    chk("mid reset ram_en", {31'h0, ram_en}, 32'h0);
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    repeat (20) @(posedge clk);
    chk("no done after reset", 32'(done_cnt - d0), 32'h0);
    drain(1, 0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ro_ram_reader.md
# ro_ram_reader

Read-side drain engine for the ring-oscillator sample RAM. After a measurement run, it walks the RAM read port from address 0 up to the number of stored samples. Each 32-bit count is sent as four bytes, MSB first, on a valid/ready byte stream toward the host link (UART/debug uplink). It replaces manual `read_enable` toggling, runs entirely in the read clock domain, and drives the RAM's port B.

## Interface
Parameters:
- `ADDR_W`, default 13: RAM address width. Depth is 2^ADDR_W = 8192 words.
- `RD_LATENCY`, default 1: RAM port-B read latency in cycles, from `ram_en` to valid `ram_dout`. Legal range 1..3.

Ports (reset is synchronous and active-high on `rst`, sampled on `read_clk`):
- `read_clk`, input, 1: the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: single-cycle request to begin a drain. Ignored while `busy`.
- `sample_count`, input, ADDR_W+1: number of words to send, range 0..8192. Latched on an accepted `start`.
- `ram_en`, output, 1: RAM port-B enable.
- `ram_addr`, output, ADDR_W: RAM port-B address.
- `ram_dout`, input, 32: RAM port-B read data.
- `tx_data`, output, 8: stream byte.
- `tx_valid`, output, 1: `tx_data` is valid.
- `tx_ready`, input, 1: sink accepts the byte. A transfer happens when `tx_valid` and `tx_ready` are both high on a rising edge.
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`.
- `done`, output, 1: one-cycle pulse after the last byte transfers.

## Operation
- States: `IDLE`, `HDR` (only with the macro), `RD`, `WAIT`, `SEND`, `FIN`.
- `IDLE`:
  - On `start`: latch `sample_count` into `remaining`, clear `addr` to 0, set `busy`.
  - Go to `HDR` if the macro is defined. Otherwise go to `RD` if `remaining` != 0, else go to `FIN`.
- `RD`: assert `ram_en` for exactly one cycle with `ram_addr` = `addr`, then go to `WAIT`.
- `WAIT`:
  - Count RD_LATENCY cycles after the `RD` cycle.
  - Capture `ram_dout` into a 32-bit shift register on the final edge.
  - Set the byte index to 0 and go to `SEND`.
- `SEND`:
  - `tx_valid` = 1 and `tx_data` = shift[31:24].
  - On each transfer, shift left by 8 and increment the byte index.
  - After the 4th transfer: decrement `remaining` and increment `addr`. Go to `RD` if `remaining` is not yet 0 after the decrement, else go to `FIN`.
- `FIN`: pulse `done`, drop `busy`, go to `IDLE`.
- `ram_en` is 0 in every state except `RD`. No speculative or overlapping reads.
- Address width rules:
  - `addr` is ADDR_W bits and never wraps within a drain.
  - For `sample_count` = 8192, the last address read is 8191.
  - `sample_count` > 8192 is clamped to 8192.
- `start` during `busy` is dropped, not queued.

## Timing
- Reset values: `ram_en`=0, `ram_addr`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `done`=0, state `IDLE`.
- Reset mid-drain: all outputs take their reset values on the same edge. Nothing resumes; the next `start` begins at address 0.
- With RD_LATENCY=1 and no header, `start` high in cycle 0 gives:
  - `ram_en` in cycle 1, address 0.
  - `ram_dout` captured at the end of cycle 2.
  - `tx_valid` in cycle 3.
- Per word with `tx_ready` held high: 1 (RD) + RD_LATENCY + 4 cycles.
- `tx_data` stays stable while `tx_valid` && !`tx_ready`. `tx_valid` never drops without a transfer, except on `rst`.
- `done` is asserted in the cycle after the final transfer. `busy` is 0 in the same cycle as `done`.
- `sample_count` = 0 without the header gives `done` in cycle 2, with no `tx_valid` and no `ram_en`.

## Configuration
- `RO_READER_HEADER_EN` defined:
  - Before the data, `HDR` sends 4 bytes: 0xA5, 0x5A, then the latched count as 16 bits, MSB first.
  - Each header byte uses the same valid/ready rules.
  - A count of 0 still sends the header, then goes to `FIN`.
- `RO_READER_HEADER_EN` undefined: `HDR` is not built and the stream carries raw data bytes only.

## Test plan
- Count 3, RAM[0..2] = 0x11223344, 0xAABBCCDD, 0x00000001, `tx_ready`=1 -> bytes 11 22 33 44 AA BB CC DD 00 00 00 01; `ram_addr` 0,1,2; a single `done` pulse.
- Same data, `tx_ready` random 50% -> identical byte sequence; `tx_data` held while stalled; no duplicated or dropped bytes.
- Count 0, macro off -> `done` 2 cycles after `start`; `tx_valid` and `ram_en` never assert.
- Count 8192, RAM[i]=i -> 32768 bytes; last word 0x00001FFF read from address 8191; `ram_addr` never wraps to 0 during the drain.
- `rst` asserted after the 5th byte of a count-3 drain -> `tx_valid`=0 and `busy`=0 on the next edge; a new `start` with count 1 sends RAM[0].
- Macro on, count 3 -> A5 5A 00 03 followed by the 12 data bytes; `start` pulsed mid-drain is ignored.
